wb_arbiter_2m: RTL and testbench

Two-master, one-slave Wishbone classic arbiter for the 7-bit-address, 8-bit-data CSR bus. It shares the CSR slave between the serial-bridge master (m0) and a second on-chip master (m1) using round-robin grants. A grant is held for the full duration of the master's `cyc`. A bus-timeout watchdog completes a stalled strobe so neither master can hang the bus.

---
 rtl/wb_arbiter_2m.sv | 133 +++++++++++++
 tb/tb_wb_arbiter_2m.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone classic arbiter with round-robin grants,
// grant lock for the full cyc, and a strobe watchdog that force-completes stalls.
module wb_arbiter_2m #(
    parameter int ADR_W   = 7,
    parameter int DAT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    output logic [DAT_W-1:0] m0_dat_o,
    input  logic             m0_we_i,
    input  logic             m0_stb_i,
    input  logic             m0_cyc_i,
    output logic             m0_ack_o,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    output logic [DAT_W-1:0] m1_dat_o,
    input  logic             m1_we_i,
    input  logic             m1_stb_i,
    input  logic             m1_cyc_i,
    output logic             m1_ack_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    input  logic [DAT_W-1:0] s_dat_i,
    output logic             s_we_o,
    output logic             s_stb_o,
    output logic             s_cyc_o,
    input  logic             s_ack_i,
    output logic [1:0]       gnt_o,
    output logic             tmo_o,
    input  logic             tmo_clr_i
);

    // State encoding is the one-hot grant itself, so gnt_o doubles as the FSM state view.
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] GNT0 = 2'b01;
    localparam logic [1:0] GNT1 = 2'b10;

    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       last;
    logic [7:0] tcnt;
    logic       tmo_q;
    logic       arb;
    logic       g0;
    logic       g1;
    logic       g_stb;
    logic       tmo_fire;

    assign g0 = (state == GNT0);
    assign g1 = (state == GNT1);

    // Re-arbitrate only when idle or when the owner has released cyc.
    always_comb begin
        state_nxt = state;
        arb       = g0 ? !m0_cyc_i : (g1 ? !m1_cyc_i : 1'b1);
        if (arb) begin
            if (m0_cyc_i && m1_cyc_i) begin
                state_nxt = last ? GNT0 : GNT1;
            end else if (m0_cyc_i) begin
                state_nxt = GNT0;
            end else if (m1_cyc_i) begin
                state_nxt = GNT1;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        g_stb   = 1'b0;
        if (g0) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_we_o  = m0_we_i;
            s_cyc_o = m0_cyc_i;
            g_stb   = m0_stb_i;
        end else if (g1) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_we_o  = m1_we_i;
            s_cyc_o = m1_cyc_i;
            g_stb   = m1_stb_i;
        end
    end

    assign tmo_fire = g_stb && !s_ack_i && (tcnt == TCNT_LAST);
    assign s_stb_o  = g_stb && !tmo_fire;

    // Acks are qualified by the live strobe so a late slave ack after a timeout is dropped.
    assign m0_ack_o = g0 && g_stb && (s_ack_i || tmo_fire);
    assign m1_ack_o = g1 && g_stb && (s_ack_i || tmo_fire);
    assign m0_dat_o = g0 ? (tmo_fire ? '1 : s_dat_i) : '0;
    assign m1_dat_o = g1 ? (tmo_fire ? '1 : s_dat_i) : '0;

    assign gnt_o = state;
    assign tmo_o = tmo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
            tcnt  <= 8'd0;
            tmo_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state && state_nxt == GNT0) begin
                last <= 1'b0;
            end else if (state_nxt != state && state_nxt == GNT1) begin
                last <= 1'b1;
            end
            if (state_nxt != state || !g_stb || s_ack_i || tmo_fire) begin
                tcnt <= 8'd0;
            end else begin
                tcnt <= tcnt + 8'd1;
            end
            if (tmo_fire) begin
                tmo_q <= 1'b1;
            end else if (tmo_clr_i) begin
                tmo_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: directed scenarios with literal expectations, then
// random master/slave traffic, all compared every cycle against a behavioural model.
module tb_wb_arbiter_2m;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] m_cyc = '0;
    logic [1:0] m_stb = '0;
    logic [1:0] m_we = '0;
    logic [6:0] m_adr [2];
    logic [7:0] m_dat [2];
    logic [7:0] s_dat_i = '0;
    logic       s_ack_i = 1'b0;
    logic       tmo_clr = 1'b0;

    logic [7:0] m0_dat_o, m1_dat_o, s_dat_o;
    logic [6:0] s_adr_o;
    logic       m0_ack_o, m1_ack_o, s_we_o, s_stb_o, s_cyc_o, tmo_o;
    logic [1:0] gnt_o;

    int n_checks = 0;
    int n_pass = 0;
    logic chk_en = 1'b0;
    logic [1:0] ack_seen = '0;

    always #5 clk = ~clk;

    wb_arbiter_2m #(.ADR_W(7), .DAT_W(8), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_dat_o(m0_dat_o),
        .m0_we_i(m_we[0]), .m0_stb_i(m_stb[0]), .m0_cyc_i(m_cyc[0]), .m0_ack_o(m0_ack_o),
        .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_dat_o(m1_dat_o),
        .m1_we_i(m_we[1]), .m1_stb_i(m_stb[1]), .m1_cyc_i(m_cyc[1]), .m1_ack_o(m1_ack_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_we_o(s_we_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_ack_i(s_ack_i),
        .gnt_o(gnt_o), .tmo_o(tmo_o), .tmo_clr_i(tmo_clr)
    );

    // ---------------- behavioural model ----------------
    int owner = -1;      // -1 idle, else index of the master holding the bus
    int last_m = 1;
    int wait_n = 0;      // consecutive unacked strobe cycles of the owner
    bit tmo_m = 1'b0;
    bit model_valid = 1'b0;
    int nxt;
    bit u_stb, u_fire;

    function automatic bit own_stb();
        if (owner < 0) return 1'b0;
        return (owner == 1) ? m_stb[1] : m_stb[0];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            owner = -1; last_m = 1; wait_n = 0; tmo_m = 1'b0; model_valid = 1'b1;
        end else if (model_valid) begin
            u_stb  = own_stb();
            u_fire = u_stb && !s_ack_i && (wait_n == TMO - 1);
            nxt = owner;
            if (owner < 0 || !((owner == 1) ? m_cyc[1] : m_cyc[0])) begin
                if (m_cyc == 2'b11)  nxt = 1 - last_m;
                else if (m_cyc[0])   nxt = 0;
                else if (m_cyc[1])   nxt = 1;
                else                 nxt = -1;
            end
            if (nxt >= 0 && nxt != owner) last_m = nxt;
            wait_n = (nxt != owner || !u_stb || s_ack_i || u_fire) ? 0 : wait_n + 1;
            if (u_fire) tmo_m = 1'b1;
            else if (tmo_clr) tmo_m = 1'b0;
            owner = nxt;
        end
    end

    // Packed view: gnt, s_adr, s_dat, s_we, s_stb, s_cyc, m0_ack, m0_dat, m1_ack, m1_dat, tmo.
    function automatic logic [38:0] model_out();
        bit gs, fire, g;
        logic [1:0] gnt;
        logic [6:0] adr;
        logic [7:0] wd, rd;
        logic we, cyc, ack0, ack1;
        logic [7:0] d0, d1;
        g    = (owner >= 0);
        gs   = own_stb();
        fire = gs && !s_ack_i && (wait_n == TMO - 1);
        gnt  = (owner == 0) ? 2'b01 : ((owner == 1) ? 2'b10 : 2'b00);
        adr  = !g ? 7'd0 : ((owner == 1) ? m_adr[1] : m_adr[0]);
        wd   = !g ? 8'd0 : ((owner == 1) ? m_dat[1] : m_dat[0]);
        we   = g && ((owner == 1) ? m_we[1] : m_we[0]);
        cyc  = g && ((owner == 1) ? m_cyc[1] : m_cyc[0]);
        rd   = fire ? 8'hFF : s_dat_i;
        ack0 = (owner == 0) && gs && (s_ack_i || fire);
        ack1 = (owner == 1) && gs && (s_ack_i || fire);
        d0   = (owner == 0) ? rd : 8'd0;
        d1   = (owner == 1) ? rd : 8'd0;
        return {gnt, adr, wd, we, gs && !fire, cyc, ack0, d0, ack1, d1, tmo_m};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        else n_pass++;
    endtask

    always @(negedge clk) begin
        ack_seen = {m1_ack_o, m0_ack_o};
        if (chk_en)
            check("cycle", {25'd0, gnt_o, s_adr_o, s_dat_o, s_we_o, s_stb_o, s_cyc_o,
                            m0_ack_o, m0_dat_o, m1_ack_o, m1_dat_o, tmo_o},
                  {25'd0, model_out()});
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic req(input int i, input logic we, input logic [6:0] adr, input logic [7:0] dat);
        m_cyc[i] = 1'b1; m_stb[i] = 1'b1; m_we[i] = we; m_adr[i] = adr; m_dat[i] = dat;
    endtask

    task automatic drop(input int i);
        m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
    endtask

    // Slave acks the granted master i with data d, master i then releases.
    task automatic serve(input int i, input logic [7:0] d);
        s_ack_i = 1'b1; s_dat_i = d;
        neg();
        check("ack_owner", (i == 0) ? {m0_ack_o, m0_dat_o} : {m1_ack_o, m1_dat_o}, {1'b1, d});
        check("ack_other", (i == 0) ? {m1_ack_o, m1_dat_o} : {m0_ack_o, m0_dat_o}, 9'd0);
        tick();
        s_ack_i = 1'b0;
        drop(i);
    endtask

    task automatic tie_round(input int first);
        req(0, 1'b0, 7'h10, 8'h00);
        req(1, 1'b0, 7'h20, 8'h00);
        tick();
        neg(); check("tie_first", gnt_o, (first == 0) ? 2'b01 : 2'b10);
        serve(first, 8'h3C);
        neg(); check("tie_hold", gnt_o, (first == 0) ? 2'b01 : 2'b10);
        tick();
        neg(); check("tie_handover", gnt_o, (first == 0) ? 2'b10 : 2'b01);
        serve(1 - first, 8'h5A);
        tick();
    endtask

    int left [2];
    int quiet = 0;

    task automatic rand_step();
        rst = ($urandom_range(0, 299) == 0);
        tmo_clr = ($urandom_range(0, 15) == 0);
        s_dat_i = 8'($urandom_range(0, 255));
        if (quiet > 0) begin
            s_ack_i = 1'b0; quiet--;
        end else begin
            s_ack_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) quiet = $urandom_range(3, 8);
        end
        for (int i = 0; i < 2; i++) begin
            if (m_cyc[i]) begin
                if (m_stb[i] && ack_seen[i]) begin
                    left[i]--;
                    if (left[i] <= 0) drop(i);
                    else begin
                        m_stb[i] = 1'($urandom_range(0, 1));
                        m_adr[i] = 7'($urandom_range(0, 127)); m_dat[i] = 8'($urandom_range(0, 255));
                        m_we[i] = 1'($urandom_range(0, 1));
                    end
                end else if (!m_stb[i]) begin
                    m_stb[i] = 1'($urandom_range(0, 1));
                end
            end else if ($urandom_range(0, 2) == 0) begin
                req(i, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)));
                m_stb[i] = 1'($urandom_range(0, 1));
                left[i] = $urandom_range(1, 3);
            end
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        m_adr[0] = '0; m_adr[1] = '0; m_dat[0] = '0; m_dat[1] = '0;
        tick(); tick();
        chk_en = 1'b1;
        neg(); check("reset_gnt", {gnt_o, s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, tmo_o}, 7'd0);
        rst = 1'b0;

        // Simultaneous requests after reset: m0 first, then m1 with no bubble.
        tie_round(0);

        // m0 write 0x05/0xA5, slave acks one cycle after strobe.
        req(0, 1'b1, 7'h05, 8'hA5);
        neg(); check("wr_pre_gnt", gnt_o, 2'b00);
        tick();
        neg(); check("wr_gnt", {gnt_o, s_adr_o, s_dat_o, s_we_o, s_stb_o, s_cyc_o}, {2'b01, 7'h05, 8'hA5, 3'b111});
        check("wr_wait_ack", {m0_ack_o, m1_ack_o}, 2'b00);
        tick();
        serve(0, 8'h00);
        neg(); check("wr_ack_once", {m0_ack_o, m1_ack_o}, 2'b00);
        tick();

        // m0 was last granted, so the next tie goes to m1.
        tie_round(1);

        // m1 locks the bus across three reads while m0 waits.
        req(1, 1'b0, 7'h30, 8'h00);
        tick();
        req(0, 1'b0, 7'h31, 8'h00);
        for (int k = 0; k < 3; k++) begin
            s_ack_i = 1'b1; s_dat_i = 8'(k + 1);
            neg(); check("lock_ack", {gnt_o, m1_ack_o, m1_dat_o, m0_ack_o}, {2'b10, 1'b1, 8'(k + 1), 1'b0});
            tick();
            s_ack_i = 1'b0;
            neg(); check("lock_gap", {gnt_o, m0_ack_o}, {2'b10, 1'b0});
            tick();
        end
        drop(1);
        tick();
        neg(); check("lock_release", gnt_o, 2'b01);
        serve(0, 8'h77);
        tick();

        // Slave never acks: forced completion on the 4th strobe cycle.
        req(0, 1'b0, 7'h11, 8'h00);
        tick(); tick(); tick(); tick();
        neg(); check("tmo_fire", {m0_ack_o, m0_dat_o, s_stb_o, s_cyc_o, tmo_o}, {1'b1, 8'hFF, 1'b0, 1'b1, 1'b0});
        tick();
        drop(0);
        neg(); check("tmo_set", tmo_o, 1'b1);
        tick();
        neg(); check("tmo_sticky", tmo_o, 1'b1);
        tmo_clr = 1'b1;
        tick();
        tmo_clr = 1'b0;
        neg(); check("tmo_clear", tmo_o, 1'b0);

        // Timeout and clear in the same cycle: set wins.
        req(0, 1'b0, 7'h12, 8'h00);
        tick(); tick(); tick(); tick();
        tmo_clr = 1'b1;
        neg(); check("tmo_fire2", {m0_ack_o, m0_dat_o}, {1'b1, 8'hFF});
        tick();
        tmo_clr = 1'b0;
        drop(0);
        neg(); check("tmo_set_wins", tmo_o, 1'b1);
        tick();

        // Reset while m1 is granted and waiting for ack.
        req(1, 1'b0, 7'h40, 8'h00);
        tick();
        neg(); check("rst_pre_gnt", gnt_o, 2'b10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req(0, 1'b0, 7'h41, 8'h00);
        neg(); check("rst_idle", {gnt_o, s_stb_o, s_cyc_o, m0_ack_o, m1_ack_o, tmo_o}, 7'd0);
        tick();
        neg(); check("rst_tie_m0", gnt_o, 2'b01);
        serve(0, 8'h12);
        tick();
        serve(1, 8'h34);
        tick(); tick();

        // Random traffic against the model.
        left[0] = 0; left[1] = 0;
        for (int c = 0; c < 4000; c++) begin
            rand_step();
            tick();
        end
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
